// File: rtl/booth_product_collector.sv
// ============================================================================
// Module   : booth_product_collector
// Purpose  : Pairs Booth-multiplier output halves into 10-bit products and
//            buffers them in a 2-entry FIFO with sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_product_collector (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic       sel,
    input  logic [4:0] data_in,
    input  logic       prod_ready,
    input  logic       clr_flags,
    output logic       prod_valid,
    output logic [9:0] product,
    output logic       prod_zero,
    output logic       prod_neg,
    output logic       proto_err,
    output logic       ovf_err,
    output logic [7:0] count
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        HI_HELD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  hi_q, hi_d;
    logic        push, proto_evt;

    logic [9:0]  mem_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  occ_q, occ_d;
    logic [7:0]  count_q;
    logic        proto_q, ovf_q;

    logic        pop, full, accept, drop;
    logic [9:0]  head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        push      = 1'b0;
        proto_evt = 1'b0;
        if (done) begin
            case (state_q)
                IDLE: begin
                    if (!sel) begin
                        hi_d    = data_in;
                        state_d = HI_HELD;
                    end else begin
                        proto_evt = 1'b1;
                    end
                end
                HI_HELD: begin
                    if (sel) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // A repeated upper half replaces the stale one.
                        hi_d      = data_in;
                        proto_evt = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop    = (occ_q != 2'd0) && prod_ready;
    assign full   = (occ_q == 2'd2);
    // When full, a same-cycle pop frees the slot the write pointer targets.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        occ_d = occ_q;
        if (accept && !pop)
            occ_d = occ_q + 2'd1;
        else if (!accept && pop)
            occ_d = occ_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= 10'd0;
            mem_q[1] <= 10'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            count_q  <= 8'd0;
            proto_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= {hi_q, data_in};
                wr_ptr_q        <= ~wr_ptr_q;
                count_q         <= count_q + 8'd1;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_d;
            if (proto_evt)
                proto_q <= 1'b1;
            else if (clr_flags)
                proto_q <= 1'b0;
            if (drop)
                ovf_q <= 1'b1;
            else if (clr_flags)
                ovf_q <= 1'b0;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign prod_valid = (occ_q != 2'd0);
    assign product    = head;
    assign prod_zero  = prod_valid && (head == 10'd0);
    assign prod_neg   = head[9];
    assign proto_err  = proto_q;
    assign ovf_err    = ovf_q;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_product_collector.sv
// ============================================================================
// Module   : tb_booth_product_collector
// Purpose  : Table-driven cycle vectors plus a count-wrap sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_product_collector;

    logic       clk = 1'b0;
    logic       rst, done, sel, prod_ready, clr_flags;
    logic [4:0] data_in;
    logic       prod_valid, prod_zero, prod_neg, proto_err, ovf_err;
    logic [9:0] product;
    logic [7:0] count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_product_collector dut (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .sel        (sel),
        .data_in    (data_in),
        .prod_ready (prod_ready),
        .clr_flags  (clr_flags),
        .prod_valid (prod_valid),
        .product    (product),
        .prod_zero  (prod_zero),
        .prod_neg   (prod_neg),
        .proto_err  (proto_err),
        .ovf_err    (ovf_err),
        .count      (count)
    );

    // Inputs applied for one cycle, outputs expected just after the edge.
    typedef struct {
        logic       r, d, s;
        logic [4:0] din;
        logic       rdy, clr;
        logic       v;
        logic [9:0] p;
        logic       z, n, pe, oe;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic d, input logic s,
                                input logic [4:0] din, input logic rdy,
                                input logic clr, input logic v,
                                input logic [9:0] p, input logic z,
                                input logic n, input logic pe, input logic oe,
                                input logic [7:0] cnt);
        vec_t t;
        t.r = r; t.d = d; t.s = s; t.din = din; t.rdy = rdy; t.clr = clr;
        t.v = v; t.p = p; t.z = z; t.n = n; t.pe = pe; t.oe = oe; t.cnt = cnt;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int idx, input int got,
                       input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s [%0d]: got %0h want %0h", name, idx, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic s,
                         input logic [4:0] din, input logic rdy,
                         input logic clr);
        rst = r; done = d; sel = s; data_in = din;
        prod_ready = rdy; clr_flags = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   r d s din    rdy clr | v  prod    z n pe oe cnt
        add(1,0,0,5'h00, 0,0,     0, 10'h000, 0,0,0, 0, 8'd0);   // reset
        add(0,1,0,5'h1F, 1,0,     0, 10'h000, 0,0,0, 0, 8'd0);   // hi=11111
        add(0,1,1,5'h14, 1,0,     1, 10'h3F4, 0,1,0, 0, 8'd1);   // pair -> 3F4
        add(0,0,0,5'h00, 1,0,     0, 10'h000, 0,0,0, 0, 8'd1);   // popped
        add(1,0,0,5'h00, 0,0,     0, 10'h000, 0,0,0, 0, 8'd0);   // reset
        add(0,1,0,5'h00, 0,0,     0, 10'h000, 0,0,0, 0, 8'd0);
        add(0,1,1,5'h01, 0,0,     1, 10'h001, 0,0,0, 0, 8'd1);
        add(0,1,0,5'h00, 0,0,     1, 10'h001, 0,0,0, 0, 8'd1);
        add(0,1,1,5'h02, 0,0,     1, 10'h001, 0,0,0, 0, 8'd2);   // full
        add(0,1,0,5'h00, 0,0,     1, 10'h001, 0,0,0, 0, 8'd2);
        add(0,1,1,5'h03, 0,0,     1, 10'h001, 0,0,0, 1, 8'd2);   // dropped
        add(0,0,0,5'h00, 1,0,     1, 10'h002, 0,0,0, 1, 8'd2);
        add(0,0,0,5'h00, 1,0,     0, 10'h000, 0,0,0, 1, 8'd2);
        add(0,0,0,5'h00, 0,1,     0, 10'h000, 0,0,0, 0, 8'd2);   // clr ovf
        add(0,1,1,5'h1F, 0,0,     0, 10'h000, 0,0,1, 0, 8'd2);   // lone lo
        add(0,1,0,5'h05, 0,0,     0, 10'h000, 0,0,1, 0, 8'd2);
        add(0,1,0,5'h06, 0,0,     0, 10'h000, 0,0,1, 0, 8'd2);   // overwrite
        add(0,1,1,5'h00, 0,0,     1, 10'h0C0, 0,0,1, 0, 8'd3);
        add(0,0,0,5'h00, 0,1,     1, 10'h0C0, 0,0,0, 0, 8'd3);   // held
        add(0,1,1,5'h07, 0,1,     1, 10'h0C0, 0,0,1, 0, 8'd3);   // err wins
        add(0,0,0,5'h00, 1,0,     0, 10'h000, 0,0,1, 0, 8'd3);
        add(0,0,0,5'h00, 0,1,     0, 10'h000, 0,0,0, 0, 8'd3);
        add(0,1,0,5'h00, 0,0,     0, 10'h000, 0,0,0, 0, 8'd3);
        add(0,1,1,5'h0A, 0,0,     1, 10'h00A, 0,0,0, 0, 8'd4);
        add(0,1,0,5'h00, 0,0,     1, 10'h00A, 0,0,0, 0, 8'd4);
        add(0,1,1,5'h0B, 0,0,     1, 10'h00A, 0,0,0, 0, 8'd5);   // full
        add(0,1,0,5'h00, 0,0,     1, 10'h00A, 0,0,0, 0, 8'd5);
        add(0,1,1,5'h0C, 1,0,     1, 10'h00B, 0,0,0, 0, 8'd6);   // push+pop
        add(0,0,0,5'h00, 1,0,     1, 10'h00C, 0,0,0, 0, 8'd6);
        add(0,0,0,5'h00, 1,0,     0, 10'h000, 0,0,0, 0, 8'd6);
        add(0,1,0,5'h15, 0,0,     0, 10'h000, 0,0,0, 0, 8'd6);   // HI_HELD
        add(1,0,0,5'h00, 0,0,     0, 10'h000, 0,0,0, 0, 8'd0);   // reset mid-pair
        add(0,1,1,5'h03, 0,0,     0, 10'h000, 0,0,1, 0, 8'd0);
        add(0,1,0,5'h00, 0,0,     0, 10'h000, 0,0,1, 0, 8'd0);
        add(0,1,1,5'h00, 0,0,     1, 10'h000, 1,0,1, 0, 8'd1);   // zero
        add(0,0,0,5'h00, 1,0,     0, 10'h000, 0,0,1, 0, 8'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].d, vecs[i].s, vecs[i].din,
                  vecs[i].rdy, vecs[i].clr);
            chk("prod_valid", i, int'(prod_valid), int'(vecs[i].v));
            chk("proto_err",  i, int'(proto_err),  int'(vecs[i].pe));
            chk("ovf_err",    i, int'(ovf_err),    int'(vecs[i].oe));
            chk("count",      i, int'(count),      int'(vecs[i].cnt));
            if (vecs[i].v || vecs[i].r) begin
                chk("product",   i, int'(product),   int'(vecs[i].p));
                chk("prod_zero", i, int'(prod_zero), int'(vecs[i].z));
                chk("prod_neg",  i, int'(prod_neg),  int'(vecs[i].n));
            end
        end

        // Count wrap: 256 pairs streamed through with the consumer ready.
        drive(1, 0, 0, 5'h00, 1, 0);
        for (int k = 0; k < 256; k++) begin
            logic [9:0] val;
            val = 10'(k * 3);
            drive(0, 1, 0, val[9:5], 1, 0);
            drive(0, 1, 1, val[4:0], 1, 0);
            chk("wrap_product", k, int'(product), int'(val));
            chk("wrap_valid",   k, int'(prod_valid), 1);
            if (k == 254)
                chk("count_255", k, int'(count), 255);
        end
        chk("count_wrap", 256, int'(count), 0);
        chk("wrap_ovf",   256, int'(ovf_err), 0);
        chk("wrap_proto", 256, int'(proto_err), 0);
        drive(0, 0, 0, 5'h00, 1, 0);
        chk("wrap_drain", 257, int'(prod_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/booth_product_collector.md
BOOTH_PRODUCT_COLLECTOR -- requirements
Module: booth_product_collector

Interface
REQ-001 The module SHALL have the following ports:
  clk        input   1   rising-edge clock; the only clock.
  rst        input   1   synchronous reset, active-high.
  done       input   1   multiplier output-phase strobe.
  sel        input   1   multiplier half select: 0 = upper half (bits 9:5), 1 = lower half (bits 4:0).
  data_in    input   5   multiplier data_out, valid while done=1.
  prod_ready input   1   consumer can accept a product this cycle.
  clr_flags  input   1   clears the sticky error flags.
  prod_valid output  1   head FIFO entry valid.
  product    output  10  head product, two's complement.
  prod_zero  output  1   head product equals 0.
  prod_neg   output  1   head product bit 9.
  proto_err  output  1   sticky protocol-violation flag.
  ovf_err    output  1   sticky FIFO-overflow flag.
  count      output  8   products accepted into the FIFO, mod 256.
REQ-002 All outputs SHALL be registered or decoded only from registered state; no combinational path SHALL exist from any input to any output.

Function
REQ-003 The assembler FSM SHALL have two states: IDLE and HI_HELD.
REQ-004 In IDLE, done=1 with sel=0 SHALL latch data_in into the hi register and move the FSM to HI_HELD.
REQ-005 In HI_HELD, done=1 with sel=1 SHALL form {hi, data_in} as a 10-bit product, issue a push, and return the FSM to IDLE.
REQ-006 In HI_HELD, done=1 with sel=0 SHALL overwrite hi with data_in, keep the FSM in HI_HELD, and set proto_err.
REQ-007 In IDLE, done=1 with sel=1 SHALL be discarded and SHALL set proto_err; the FSM SHALL stay in IDLE.
REQ-008 done=0 SHALL cause no state change; HI_HELD SHALL be held indefinitely without a timeout.
REQ-009 The output buffer SHALL be a 2-entry FIFO with wrapping 1-bit read/write pointers and a 2-bit occupancy count.
REQ-010 A pop SHALL occur on any cycle where prod_valid=1 and prod_ready=1.
REQ-011 When a push and a pop occur in the same cycle, both SHALL be performed and occupancy SHALL stay unchanged; this also applies when the FIFO is full.
REQ-012 A push into a full FIFO without a same-cycle pop SHALL drop the product, set ovf_err, and leave count unchanged.
REQ-013 Each accepted push SHALL increment count, wrapping from 255 to 0.
REQ-014 Latency: a product pushed at clock edge N SHALL appear with prod_valid=1 after edge N when the FIFO was empty; otherwise it SHALL appear behind the older entries in order.
REQ-015 product, prod_zero and prod_neg SHALL reflect the head entry whenever prod_valid=1; their values are don't-care when prod_valid=0.
REQ-016 prod_valid SHALL be 1 exactly when occupancy is nonzero.
REQ-017 product, prod_zero and prod_neg SHALL be held stable while prod_valid=1 and prod_ready=0.
REQ-018 clr_flags=1 SHALL clear proto_err and ovf_err at the next edge.
REQ-019 If an error event and clr_flags occur in the same cycle, the error event SHALL win and the flag SHALL be set.

Reset
REQ-020 rst=1 at a clock edge SHALL force: FSM=IDLE, hi=0, FIFO empty, pointers=0, prod_valid=0, product=0, prod_zero=0, prod_neg=0, proto_err=0, ovf_err=0, count=0.
REQ-021 rst SHALL take priority over every other input, including when asserted mid-pair in HI_HELD; the held half-product SHALL be discarded.

Verification
REQ-022 Pair sequence: done,sel=0, data_in=5'b11111, then done,sel=1, data_in=5'b10100, with prod_ready=1 -> product=10'h3F4, prod_neg=1, prod_zero=0, count=1, valid for 1 cycle.
REQ-023 Back-pressure: three pairs (0x001, 0x002, 0x003) with prod_ready=0 -> third pair dropped, ovf_err=1, count=2; then prod_ready=1 -> pops 0x001 then 0x002, prod_valid=0 afterwards.
REQ-024 Protocol errors: done,sel=1 in IDLE -> proto_err=1, no push; then sel=0 (0x05), sel=0 (0x06), sel=1 (0x00) -> product=10'h0C0, proto_err still set until a clr_flags pulse.
REQ-025 Full FIFO with simultaneous pop and push -> push accepted, ovf_err stays 0, occupancy stays 2, output order preserved.
REQ-026 rst asserted in HI_HELD, then a lone sel=1 strobe -> proto_err=1 and no product; a zero pair -> prod_zero=1.
REQ-027 256 accepted products -> count wraps to 0.
